// File: rtl/ic_result_reporter.sv
// Purpose: serialises one checker verdict per result_valid strobe into a UART 8N1 frame.
// Latency: start bit on tx the cycle after acceptance; frame lasts 30 (40 with checksum) bit times.
// Backpressure: none; result_valid while busy is dropped and remembered as a sticky overrun flag.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   reset         asynchronous, active-high reset
//   result_valid  one-cycle strobe, verdict inputs are final
//   pass1..pass3  per-gate pass verdicts
//   fail1..fail3  per-gate fail verdicts
//   tx            UART line, LSB first, idle high
//   busy          high while a frame is in flight
//   frame_done    one-cycle pulse when the last stop bit completes
//
// Frame: 0xA5, run_count (pre-increment), status
//   status = {overrun, all_pass, fail3, fail2, fail1, pass3, pass2, pass1}
// Build option: define RESULT_CHECKSUM_EN to append XOR of the three bytes as a fourth byte.

module ic_result_reporter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic result_valid,
    input  logic pass1,
    input  logic pass2,
    input  logic pass3,
    input  logic fail1,
    input  logic fail2,
    input  logic fail3,
    output logic tx,
    output logic busy,
    output logic frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    // STOP lasts one cycle less than a bit; the NEXT state supplies the final
    // stop-bit cycle, so byte-to-byte spacing has no idle gap.
    localparam logic [CW-1:0] CNT_STOP_LAST = CW'(CLKS_PER_BIT - 2);
    localparam logic [7:0] HEADER = 8'hA5;

`ifdef RESULT_CHECKSUM_EN
    localparam int NUM_BYTES = 4;
`else
    localparam int NUM_BYTES = 3;
`endif
    localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_NEXT
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [1:0]      byte_q;
    logic [7:0]      shift_q;
    logic [7:0]      run_count_q;
    logic [7:0]      run_byte_q;
    logic [7:0]      status_q;
    logic            overrun_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;

    logic [7:0]      status_d;
    logic [7:0]      next_byte_d;

    // Status byte assembled from the live inputs; only captured on acceptance.
    always_comb begin
        status_d = {overrun_q, (pass1 & pass2 & pass3),
                    fail3, fail2, fail1,
                    pass3, pass2, pass1};
    end

    // Byte following the one currently indexed by byte_q.
    always_comb begin
        next_byte_d = 8'h00;
        case (byte_q)
            2'd0:    next_byte_d = run_byte_q;
            2'd1:    next_byte_d = status_q;
`ifdef RESULT_CHECKSUM_EN
            2'd2:    next_byte_d = HEADER ^ run_byte_q ^ status_q;
`endif
            default: next_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            shift_q     <= '0;
            run_count_q <= '0;
            run_byte_q  <= '0;
            status_q    <= '0;
            overrun_q   <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Any strobe outside IDLE is lost; remember that it happened.
            if (result_valid && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (result_valid) begin
                        state_q     <= S_START;
                        tx_q        <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        bit_q       <= '0;
                        byte_q      <= '0;
                        shift_q     <= HEADER;
                        run_byte_q  <= run_count_q;
                        run_count_q <= run_count_q + 8'd1;
                        status_q    <= status_d;
                        overrun_q   <= 1'b0;
                    end
                end

                S_START: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            // With one cycle per bit the whole stop bit is the NEXT cycle.
                            state_q <= (CLKS_PER_BIT == 1) ? S_NEXT : S_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_STOP: begin
                    if (cnt_q == CNT_STOP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_NEXT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_NEXT: begin
                    // Final cycle of the stop bit: chain the next byte or finish.
                    cnt_q <= '0;
                    if (byte_q == LAST_BYTE) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        byte_q  <= '0;
                    end else begin
                        byte_q  <= byte_q + 2'd1;
                        shift_q <= next_byte_d;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ic_result_reporter.sv
// Purpose: scoreboard bench for ic_result_reporter with a UART decoder on tx.
// Latency: expected bytes queued when result_valid is driven, compared after each frame.
// Backpressure: none; strobes during a frame are modelled as overruns.
`timescale 1ns/1ps

module tb_ic_result_reporter;

    localparam int CPB = 4;
`ifdef RESULT_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int FRAME_CYC = NB * 10 * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic result_valid = 1'b0;
    logic pass1 = 1'b0, pass2 = 1'b0, pass3 = 1'b0;
    logic fail1 = 1'b0, fail2 = 1'b0, fail3 = 1'b0;
    logic tx, busy, frame_done;

    always #5 clk = ~clk;

    ic_result_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .result_valid (result_valid),
        .pass1        (pass1),
        .pass2        (pass2),
        .pass3        (pass3),
        .fail1        (fail1),
        .fail2        (fail2),
        .fail3        (fail3),
        .tx           (tx),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state and scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] exp_run = 8'h00;
    logic       exp_ovr = 1'b0;

    // Decoded bytes from tx, written only by the decoder
    logic [7:0] rx_q[$];
    logic       rx_stop_q[$];
    int         rx_rd = 0;

    int busy_cycles = 0;
    int done_cnt    = 0;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cycles++;
        if (frame_done === 1'b1) done_cnt++;
    end

    // UART decoder: samples the middle of each bit counting from the first low sample.
    int         m_cnt = 0;
    logic       m_act = 1'b0;
    logic [7:0] m_sh  = 8'h00;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (tx === 1'b0) begin
                m_act = 1'b1;
                m_cnt = 1;
            end
        end else begin
            m_cnt++;
            if (m_cnt > CPB && m_cnt <= 9 * CPB && (m_cnt % CPB) == CPB / 2)
                m_sh = {tx, m_sh[7:1]};
            if (m_cnt == 9 * CPB + CPB / 2) begin
                rx_q.push_back(m_sh);
                rx_stop_q.push_back(tx);
                m_act = 1'b0;
            end
        end
    end

    function automatic logic [7:0] status_of(input logic ovr, input logic [2:0] p,
                                             input logic [2:0] f);
        return {ovr, &p, f, p};
    endfunction

    // Drives one strobe at the current negedge; returns one cycle later.
    task automatic send(input logic [2:0] p, input logic [2:0] f, input bit expect_accept);
        logic [7:0] st;
        {pass3, pass2, pass1} = p;
        {fail3, fail2, fail1} = f;
        result_valid = 1'b1;
        if (expect_accept) begin
            st = status_of(exp_ovr, p, f);
            exp_q.push_back(8'hA5);
            exp_q.push_back(exp_run);
            exp_q.push_back(st);
`ifdef RESULT_CHECKSUM_EN
            exp_q.push_back(8'hA5 ^ exp_run ^ st);
`endif
            exp_run = exp_run + 8'd1;
            exp_ovr = 1'b0;
        end else begin
            exp_ovr = 1'b1;
        end
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        result_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q.delete();
        exp_run = 8'h00;
        exp_ovr = 1'b0;
        rx_rd = rx_q.size();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
        @(negedge clk);
        apply_reset();
    endtask

    task automatic test_all_pass();
        int b0, d0, base;
        bit ok;
        logic [7:0] e;
        b0 = busy_cycles; d0 = done_cnt; base = rx_rd;
        send(3'b111, 3'b000, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || tx !== 1'b0) begin
            n_fail++; $display("FAIL accept_start: busy=%b tx=%b want busy=1 tx=0", busy, tx);
        end
        wait_done(FRAME_CYC + 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL all_pass_timeout: frame_done=0 want 1"); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy_cycles - b0 != FRAME_CYC) begin
            n_fail++; $display("FAIL busy_len: got %0d want %0d", busy_cycles - b0, FRAME_CYC);
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL done_pulses: got %0d want 1", done_cnt - d0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_rd >= rx_q.size()) begin
                n_fail++; $display("FAIL all_pass_byte: none received want %02h", e);
            end else begin
                if (rx_q[rx_rd] !== e || rx_stop_q[rx_rd] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL all_pass_byte: got %02h stop=%b want %02h stop=1", rx_q[rx_rd], rx_stop_q[rx_rd], e);
                end
                rx_rd++;
            end
        end
        n_checks++;
        if (rx_q.size() != base + NB || rx_q[base + 2] !== 8'h47) begin
            n_fail++; $display("FAIL all_pass_status: got %02h count=%0d want 47 count=%0d", rx_q[base + 2], rx_q.size() - base, NB);
        end
`ifdef RESULT_CHECKSUM_EN
        n_checks++;
        if (rx_q[base + 3] !== 8'hE2) begin
            n_fail++; $display("FAIL checksum: got %02h want E2", rx_q[base + 3]);
        end
`endif
    endtask

    task automatic test_mixed();
        int base;
        bit ok;
        logic [7:0] e;
        base = rx_rd;
        send(3'b101, 3'b010, 1'b1);
        wait_done(FRAME_CYC + 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL mixed_timeout: frame_done=0 want 1"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_rd >= rx_q.size()) begin
                n_fail++; $display("FAIL mixed_byte: none received want %02h", e);
            end else begin
                if (rx_q[rx_rd] !== e || rx_stop_q[rx_rd] !== 1'b1) begin
                    n_fail++; $display("FAIL mixed_byte: got %02h want %02h", rx_q[rx_rd], e);
                end
                rx_rd++;
            end
        end
        n_checks++;
        if (rx_q[base + 2] !== 8'h15) begin
            n_fail++; $display("FAIL mixed_status: got %02h want 15", rx_q[base + 2]);
        end
        // Contradictory pass=fail=1 must pass straight through
        base = rx_rd;
        @(negedge clk);
        send(3'b011, 3'b110, 1'b1);
        wait_done(FRAME_CYC + 20, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_rd >= rx_q.size() || rx_q[rx_rd] !== e) begin
                n_fail++; $display("FAIL contra_byte: got %02h want %02h", rx_q[rx_rd], e);
            end
            rx_rd++;
        end
        n_checks++;
        if (rx_q[base + 2] !== 8'h33) begin
            n_fail++; $display("FAIL contra_status: got %02h want 33", rx_q[base + 2]);
        end
    endtask

    task automatic test_overrun();
        int base;
        bit ok;
        logic [7:0] e;
        apply_reset();
        base = rx_rd;
        send(3'b111, 3'b000, 1'b1);
        repeat (9) @(negedge clk);
        send(3'b000, 3'b111, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b want 1", busy); end
        wait_done(FRAME_CYC + 20, ok);
        for (int fr = 0; fr < 3; fr++) begin
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL ovr_timeout: frame %0d frame_done=0 want 1", fr); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (rx_rd >= rx_q.size() || rx_q[rx_rd] !== e) begin
                    n_fail++; $display("FAIL ovr_byte: frame %0d got %02h want %02h", fr, rx_q[rx_rd], e);
                end
                rx_rd++;
            end
            n_checks++;
            if (rx_q.size() != rx_rd) begin
                n_fail++; $display("FAIL ovr_extra: got %0d bytes want %0d", rx_q.size() - base, rx_rd - base);
            end
            if (fr == 1) begin
                n_checks++;
                if (rx_q[base + 1] !== 8'h01 || rx_q[base + 2][7] !== 1'b1) begin
                    n_fail++; $display("FAIL ovr_flag: run=%02h bit7=%b want run=01 bit7=1", rx_q[base + 1], rx_q[base + 2][7]);
                end
            end
            if (fr == 2) begin
                n_checks++;
                if (rx_q[base + 2][7] !== 1'b0) begin
                    n_fail++; $display("FAIL ovr_clear: bit7=%b want 0", rx_q[base + 2][7]);
                end
            end
            if (fr < 2) begin
                @(negedge clk);
                base = rx_rd;
                send(3'b111, 3'b000, 1'b1);
                wait_done(FRAME_CYC + 20, ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        logic [7:0] e;
        logic [7:0] want_rc;
        apply_reset();
        send(3'b110, 3'b001, 1'b1);
        for (int i = 0; i <= 256; i++) begin
            base = rx_rd;
            want_rc = 8'(i);
            wait_done(FRAME_CYC + 20, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL b2b_timeout: frame %0d frame_done=0 want 1", i); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (rx_rd >= rx_q.size() || rx_q[rx_rd] !== e) begin
                    n_fail++; $display("FAIL b2b_byte: frame %0d got %02h want %02h", i, rx_q[rx_rd], e);
                end
                rx_rd++;
            end
            n_checks++;
            if (rx_q[base + 1] !== want_rc) begin
                n_fail++; $display("FAIL b2b_run: frame %0d got %02h want %02h", i, rx_q[base + 1], want_rc);
            end
            // Strobe in the frame_done cycle itself must start the next frame.
            if (i < 256) send(3'b110, 3'b001, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        logic [7:0] e;
        apply_reset();
        send(3'b111, 3'b000, 1'b1);
        repeat (8) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_run = 8'h00;
        exp_ovr = 1'b0;
        repeat (FRAME_CYC) @(negedge clk);
        n_checks++;
        if (rx_q.size() != rx_rd || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_abandon: bytes=%0d busy=%b want bytes=0 busy=0", rx_q.size() - rx_rd, busy);
        end
        base = rx_rd;
        send(3'b111, 3'b000, 1'b1);
        wait_done(FRAME_CYC + 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL mid_timeout: frame_done=0 want 1"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_rd >= rx_q.size() || rx_q[rx_rd] !== e) begin
                n_fail++; $display("FAIL mid_byte: got %02h want %02h", rx_q[rx_rd], e);
            end
            rx_rd++;
        end
        n_checks++;
        if (rx_q[base + 1] !== 8'h00) begin
            n_fail++; $display("FAIL mid_run: got %02h want 00", rx_q[base + 1]);
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        @(negedge clk);
        test_mixed();
        @(negedge clk);
        test_overrun();
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ic_result_reporter.md
IC_RESULT_REPORTER -- requirements
Module: ic_result_reporter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port result_valid  input  1  one-cycle strobe marking checker verdicts as final.
REQ-005 SHALL have ports pass1, pass2, pass3  input  1 each  per-gate pass verdicts from the three-input checker.
REQ-006 SHALL have ports fail1, fail2, fail3  input  1 each  per-gate fail verdicts from the three-input checker.
REQ-007 SHALL have port tx  output  1  UART 8N1 serial line, LSB first, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is in flight.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when the last stop bit of a frame completes.

Function
REQ-010 SHALL accept result_valid only in IDLE, latching all six verdict inputs on that edge.
REQ-011 SHALL drive tx low (start bit) and busy high from the cycle after acceptance.
REQ-012 SHALL send frame bytes in order: 0xA5 header, run_count, status.
REQ-013 SHALL format status as bit7 overrun, bit6 all_pass (pass1&pass2&pass3 latched), bits5:3 fail3..fail1, bits2:0 pass3..pass1.
REQ-014 SHALL hold each bit (start, 8 data, stop) for exactly CLKS_PER_BIT cycles, with no idle gap between bytes.
REQ-015 SHALL use FSM states IDLE -> START -> DATA(8 bits) -> STOP -> NEXT; NEXT goes to START if bytes remain, else IDLE.
REQ-016 SHALL drop busy and pulse frame_done in the same cycle that the final stop bit ends; a result_valid in that cycle SHALL be accepted.
REQ-017 SHALL transmit run_count at its pre-increment value and increment it on acceptance; it starts at 0x00 and wraps 0xFF -> 0x00.
REQ-018 SHALL ignore result_valid while busy and set a sticky overrun flag instead.
REQ-019 SHALL report the sticky overrun flag in the next accepted frame's status bit7 and clear it on that acceptance; an overrun arriving during that frame SHALL set the flag again.
REQ-020 SHALL pass latched verdict bits through unchanged, including contradictory pass=fail=1 combinations.

Reset
REQ-021 SHALL on reset immediately force tx=1, busy=0, frame_done=0, run_count=0, overrun=0, FSM=IDLE and bit/byte counters to 0.
REQ-022 SHALL on reset mid-frame abandon the frame without sending the rest, and start the next frame at run_count 0x00.

Configuration
REQ-023 SHALL, with macro RESULT_CHECKSUM_EN defined, append a fourth byte equal to the XOR of the three preceding bytes, giving a frame of 40*CLKS_PER_BIT cycles.
REQ-024 SHALL, without RESULT_CHECKSUM_EN, send exactly three bytes, giving a frame of 30*CLKS_PER_BIT cycles.

Verification
REQ-025 SHALL verify: CLKS_PER_BIT=4, pass1..3=1, fail=0, one result_valid -> bytes A5,00,47 decoded; busy high exactly 120 cycles; one frame_done pulse.
REQ-026 SHALL verify: pass=3'b101, fail=3'b010 -> status 0x15, all_pass=0.
REQ-027 SHALL verify: second result_valid 10 cycles into a frame -> ignored; following accepted frame has run_count 01 and status bit7=1; the frame after that has bit7=0.
REQ-028 SHALL verify: 256 back-to-back frames -> run_count goes 00..FF then 00.
REQ-029 SHALL verify: reset asserted mid-DATA -> tx=1 and busy=0 asynchronously; next frame starts at run_count 00.
REQ-030 SHALL verify: with RESULT_CHECKSUM_EN and inputs as REQ-025 -> bytes A5,00,47,E2; busy high 160 cycles.
